// File: rtl/ysyx_22040632_mul_pkg.sv
// rtl/ysyx_22040632_mul_pkg.sv - shared types for the iterative Booth multiplier
package ysyx_22040632_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  function automatic int booth_iter(input int xlen);
    return xlen / 2 + 1;
  endfunction

  localparam int ITER = booth_iter(64);

  typedef struct packed {
    logic sel_zero;
    logic sel_x;
    logic sel_2x;
    logic neg;
  } booth_ctl_t;

  // Radix-4 Booth recoding of one overlapping bit triple
  function automatic booth_ctl_t booth_decode(input logic [2:0] triple);
    booth_ctl_t c;
    c = '{sel_zero: 1'b0, sel_x: 1'b0, sel_2x: 1'b0, neg: 1'b0};
    case (triple)
      3'b001, 3'b010: c.sel_x = 1'b1;
      3'b011:         c.sel_2x = 1'b1;
      3'b100:         begin c.sel_2x = 1'b1; c.neg = 1'b1; end
      3'b101, 3'b110: begin c.sel_x = 1'b1; c.neg = 1'b1; end
      default:        c.sel_zero = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ysyx_22040632_booth_sel.sv
// rtl/ysyx_22040632_booth_sel.sv - Booth partial-product selector
// Emits magnitude (one's complement when negative) plus the carry-in that completes negation.
module ysyx_22040632_booth_sel
  import ysyx_22040632_mul_pkg::*;
#(
  parameter int W = 128
) (
  input  logic [2:0]   i_triple,
  input  logic [W-1:0] i_x,
  output logic [W-1:0] o_mag,
  output logic         o_neg
);

  booth_ctl_t     w_ctl;
  logic [W-1:0]   w_base;

  always_comb begin
    w_ctl  = booth_decode(i_triple);
    w_base = '0;
    if (w_ctl.sel_zero)    w_base = '0;
    else if (w_ctl.sel_x)  w_base = i_x;
    else if (w_ctl.sel_2x) w_base = {i_x[W-2:0], 1'b0};
    o_mag = w_ctl.neg ? ~w_base : w_base;
    o_neg = w_ctl.neg;
  end

endmodule

// File: rtl/ysyx_22040632_mul_iter.sv
// rtl/ysyx_22040632_mul_iter.sv - iterative radix-4 Booth multiplier, 2*XLEN-bit product
// One partial product per cycle; fixed ITER-cycle latency, result held until handshake.
module ysyx_22040632_mul_iter
  import ysyx_22040632_mul_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            mul_valid,
  output logic            mul_ready,
  input  logic [1:0]      mul_signed,
  input  logic [XLEN-1:0] multiplicand,
  input  logic [XLEN-1:0] multiplier,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result_hi,
  output logic [XLEN-1:0] result_lo
);

  localparam int LP_ITER = booth_iter(XLEN);
  localparam int W2      = 2 * XLEN;
  localparam int YW      = XLEN + 3;
  localparam int CW      = $clog2(LP_ITER);
  localparam logic [CW-1:0] LP_LAST = CW'(LP_ITER - 1);

  mul_state_t      r_state;
  mul_state_t      w_state_next;
  logic [W2-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [W2-1:0]   r_acc;
  logic [W2-1:0]   r_res;
  logic [CW-1:0]   r_cnt;

  logic [W2-1:0]   w_mag;
  logic            w_neg;
  logic [W2-1:0]   w_sum;
  logic            w_accept;
  logic            w_last;

  ysyx_22040632_booth_sel #(.W(W2)) u_booth_sel (
    .i_triple (r_y[2:0]),
    .i_x      (r_x),
    .o_mag    (w_mag),
    .o_neg    (w_neg)
  );

  assign w_sum    = r_acc + w_mag + W2'(w_neg);
  assign w_accept = mul_valid && (r_state == IDLE);
  assign w_last   = (r_cnt == LP_LAST);

  assign mul_ready = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result_hi = r_res[W2-1:XLEN];
  assign result_lo = r_res[XLEN-1:0];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = BUSY;
      BUSY:    if (w_last) w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (flush) w_state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_acc   <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      // A flushed operation must never publish its accumulator
      if (!flush) begin
        case (r_state)
          IDLE: if (w_accept) begin
            r_x   <= {{XLEN{mul_signed[1] & multiplicand[XLEN-1]}}, multiplicand};
            r_y   <= {{2{mul_signed[0] & multiplier[XLEN-1]}}, multiplier, 1'b0};
            r_acc <= '0;
            r_cnt <= '0;
          end
          BUSY: begin
            r_acc <= w_sum;
            r_x   <= {r_x[W2-3:0], 2'b00};
            r_y   <= $signed(r_y) >>> 2;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) r_res <= w_sum;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22040632_mul_iter.sv
// tb/tb_ysyx_22040632_mul_iter.sv - self-checking bench for the iterative Booth multiplier
module tb_ysyx_22040632_mul_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        mul_valid;
  logic        mul_ready;
  logic [1:0]  mul_signed;
  logic [63:0] multiplicand;
  logic [63:0] multiplier;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result_hi;
  logic [63:0] result_lo;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_22040632_mul_iter dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .mul_valid    (mul_valid),
    .mul_ready    (mul_ready),
    .mul_signed   (mul_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result_hi    (result_hi),
    .result_lo    (result_lo)
  );

  function automatic logic [127:0] ref_mul(input logic [1:0] s, input logic [63:0] x,
                                           input logic [63:0] y);
    logic [127:0] xe;
    logic [127:0] ye;
    xe = s[1] ? {{64{x[63]}}, x} : {64'd0, x};
    ye = s[0] ? {{64{y[63]}}, y} : {64'd0, y};
    return xe * ye;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [1:0] s, input logic [63:0] x, input logic [63:0] y);
    mul_signed   = s;
    multiplicand = x;
    multiplier   = y;
    mul_valid    = 1'b1;
    tick();
    mul_valid    = 1'b0;
    multiplicand = {$urandom, $urandom};
    multiplier   = {$urandom, $urandom};
    mul_signed   = 2'($urandom_range(0, 3));
  endtask

  task automatic run_op(input string tag, input logic [1:0] s, input logic [63:0] x,
                        input logic [63:0] y, input logic [127:0] exp);
    out_ready = 1'b0;
    start_op(s, x, y);
    chk({tag, " busy_ready"}, 128'(mul_ready), 128'd0);
    repeat (32) tick();
    chk({tag, " early_valid"}, 128'(out_valid), 128'd0);
    tick();
    chk({tag, " valid"}, 128'(out_valid), 128'd1);
    chk({tag, " product"}, {result_hi, result_lo}, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " drop_valid"}, 128'(out_valid), 128'd0);
    chk({tag, " ready_again"}, 128'(mul_ready), 128'd1);
  endtask

  initial begin
    logic [127:0] held;
    logic         saw_valid;
    logic [1:0]   rs;
    logic [63:0]  rx;
    logic [63:0]  ry;

    rst = 1'b1; flush = 1'b0; mul_valid = 1'b0; out_ready = 1'b0;
    mul_signed = 2'b00; multiplicand = '0; multiplier = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset mul_ready", 128'(mul_ready), 128'd1);
    chk("reset out_valid", 128'(out_valid), 128'd0);
    chk("reset result", {result_hi, result_lo}, 128'd0);

    run_op("mulhu_max", 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           {64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001});
    run_op("mulh_m1", 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           {64'd0, 64'd1});
    run_op("mulh_min", 2'b11, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
           {64'h4000_0000_0000_0000, 64'd0});
    run_op("mulhsu_a", 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
           {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE});
    run_op("mulhsu_b", 2'b10, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF,
           {64'd2, 64'hFFFF_FFFF_FFFF_FFFD});

    // Backpressure with spurious requests while busy and done
    out_ready = 1'b0;
    start_op(2'b01, 64'd12345, 64'hFFFF_FFFF_FFFF_FFF0);
    mul_valid = 1'b1;
    repeat (10) tick();
    chk("bp busy_ignore", 128'(mul_ready), 128'd0);
    mul_valid = 1'b0;
    repeat (23) tick();
    chk("bp valid", 128'(out_valid), 128'd1);
    held = {result_hi, result_lo};
    chk("bp product", held, ref_mul(2'b01, 64'd12345, 64'hFFFF_FFFF_FFFF_FFF0));
    mul_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp hold_valid", 128'(out_valid), 128'd1);
      chk("bp hold_data", {result_hi, result_lo}, held);
      chk("bp done_ready", 128'(mul_ready), 128'd0);
    end
    mul_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp release_valid", 128'(out_valid), 128'd0);
    chk("bp release_ready", 128'(mul_ready), 128'd1);
    tick();
    chk("bp stays_idle", 128'(mul_ready), 128'd1);

    // Flush mid-operation at cnt=10
    start_op(2'b00, 64'hDEAD_BEEF, 64'hCAFE);
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush ready", 128'(mul_ready), 128'd1);
    chk("flush valid", 128'(out_valid), 128'd0);
    saw_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) saw_valid = 1'b1;
    end
    chk("flush never_valid", 128'(saw_valid), 128'd0);
    run_op("post_flush", 2'b00, 64'd7, 64'd6, 128'd42);

    // Reset mid-operation at cnt=20
    start_op(2'b11, 64'h1234_5678_9ABC_DEF0, 64'h8765_4321_0FED_CBA9);
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst ready", 128'(mul_ready), 128'd1);
    chk("rst valid", 128'(out_valid), 128'd0);
    chk("rst result", {result_hi, result_lo}, 128'd0);
    run_op("post_rst", 2'b11, 64'hFFFF_FFFF_FFFF_FFF9, 64'd9,
           ref_mul(2'b11, 64'hFFFF_FFFF_FFFF_FFF9, 64'd9));

    for (int i = 0; i < 12; i++) begin
      rs = 2'($urandom_range(0, 3));
      rx = {$urandom, $urandom};
      ry = {$urandom, $urandom};
      if (i == 0) rx[63] = 1'b1;
      if (i == 1) ry[63] = 1'b1;
      run_op("random", rs, rx, ry, ref_mul(rs, rx, ry));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
